// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell plus a borrow
// flip-flop, sequenced by an IDLE/RUN/DONE start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_borrow,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bf_q, bf_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             bor_q, bor_d, ovf_q, ovf_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  logic             bit_a, bit_b, dbit, bnext;
  logic [WIDTH-1:0] res_shift;

  assign bit_a     = a_q[0];
  assign bit_b     = b_q[0];
  assign dbit      = bit_a ^ bit_b ^ bf_q;
  assign bnext     = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bf_q);
  assign res_shift = {dbit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    bf_d    = bf_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bor_d   = bor_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          bf_d    = i_borrow;
          res_d   = '0;
          cnt_d   = '0;
          amsb_d  = i_a[WIDTH-1];
          bmsb_d  = i_b[WIDTH-1];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bf_d  = bnext;
        res_d = res_shift;
        cnt_d = cnt_q + 1'b1;
        // Results are published only on the last bit, so they stay stable during RUN.
        if (cnt_q == LAST) begin
          diff_d  = res_shift;
          bor_d   = bnext;
          ovf_d   = (amsb_q != bmsb_q) && (res_shift[WIDTH-1] != amsb_q);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      bf_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      bf_q    <= bf_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bor_q   <= bor_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_busy     = (state_q == S_RUN);
  assign o_done     = (state_q == S_DONE);
  assign o_diff     = diff_q;
  assign o_borrow   = bor_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit vector table, handshake corner cases,
// and an exhaustive sweep of a 4-bit instance against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n, start, bin;
  logic [7:0] a, b, diff;
  logic       busy, done, bor, ovf;

  logic       start4, bin4;
  logic [3:0] a4, b4, diff4;
  logic       busy4, done4, bor4, ovf4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b), .i_borrow(bin),
    .o_busy(busy), .o_done(done), .o_diff(diff), .o_borrow(bor), .o_overflow(ovf)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_a(a4), .i_b(b4), .i_borrow(bin4),
    .o_busy(busy4), .o_done(done4), .o_diff(diff4), .o_borrow(bor4), .o_overflow(ovf4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bor;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; that cycle is cycle 0. Returns the cycle in which
  // o_done was seen and how many cycles o_busy was high before it.
  task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                      output int lat, output int nbusy);
    a = va; b = vb; bin = vbin; start = 1'b1;
    lat = 0; nbusy = 0;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 1;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run4(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                      output int lat);
    a4 = va; b4 = vb; bin4 = vbin; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nbusy, ndone, cyc;
    int dcyc[$];

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'h01, 1'b1, 8'hFD, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", bor, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst4_all", {busy4, done4, diff4, bor4, ovf4}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].bin, lat, nbusy);
      chk($sformatf("v%0d_latency", i), lat, 9);
      chk($sformatf("v%0d_busy_cycles", i), nbusy, 8);
      chk($sformatf("v%0d_diff", i), diff, vecs[i].diff);
      chk($sformatf("v%0d_borrow", i), bor, vecs[i].bor);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      chk($sformatf("v%0d_busy_in_done", i), busy, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // Start pulse in the middle of RUN must be ignored.
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    ndone = 0;
    repeat (2) begin @(negedge clk); cyc++; end
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    chk("midrun_diff_stable", diff, 8'h0F);
    @(negedge clk); cyc++;
    start = 1'b0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("midrun_latency", cyc, 9);
    chk("midrun_diff", diff, 8'h0F);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midrun_no_second_op", ndone, 0);

    // Asynchronous reset in the fourth RUN cycle aborts the operation.
    a = 8'h33; b = 8'h11; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_flags", {bor, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run8(8'h05, 8'h03, 1'b0, lat, nbusy);
    chk("after_abort_latency", lat, 9);
    chk("after_abort_diff", diff, 8'h02);
    @(negedge clk);

    // Start held high: a new op is accepted in every DONE cycle.
    a = 8'h09; b = 8'h04; bin = 1'b1; start = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (done) begin
        dcyc.push_back(c);
        chk($sformatf("b2b_diff_c%0d", c), diff, 8'h04);
      end
    end
    start = 1'b0;
    chk("b2b_done_count", dcyc.size(), 3);
    if (dcyc.size() == 3) begin
      chk("b2b_done0", dcyc[0], 9);
      chk("b2b_done1", dcyc[1], 18);
      chk("b2b_done2", dcyc[2], 27);
    end
    @(negedge clk);
    chk("b2b_idle", {busy, done}, 0);

    // Exhaustive 4-bit sweep against an integer model.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int sa, sb, r, ediff, ebor, eovf;
          sa    = (ia >= 8) ? ia - 16 : ia;
          sb    = (ib >= 8) ? ib - 16 : ib;
          r     = sa - sb - ic;
          ediff = (ia - ib - ic) & 15;
          ebor  = (ia < ib + ic) ? 1 : 0;
          eovf  = (r < -8 || r > 7) ? 1 : 0;
          run4(4'(ia), 4'(ib), 1'(ic), lat);
          chk($sformatf("w4_lat a=%0h b=%0h c=%0d", ia, ib, ic), lat, 5);
          chk($sformatf("w4_diff a=%0h b=%0h c=%0d", ia, ib, ic), diff4, ediff);
          chk($sformatf("w4_borrow a=%0h b=%0h c=%0d", ia, ib, ic), bor4, ebor);
          chk($sformatf("w4_ovf a=%0h b=%0h c=%0d", ia, ib, ic), ovf4, eovf);
          @(negedge clk);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
